// File: rtl/bus_arbiter_pkg.sv
// rtl/bus_arbiter_pkg.sv - shared constants and state encoding for bus_arbiter
package bus_arbiter_pkg;

    localparam logic STOP          = 1'b1;
    localparam logic NO_STOP       = 1'b0;
    localparam logic WRITE_ENABLE  = 1'b1;
    localparam logic WRITE_DISABLE = 1'b0;

    localparam int STALL_IF_BIT  = 1;
    localparam int STALL_MEM_BIT = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_IF_BUS  = 2'd1,
        ARB_MEM_BUS = 2'd2,
        ARB_DISCARD = 2'd3
    } arb_state_e;

    // A requester may start a bus cycle only when it has no unconsumed result.
    function automatic logic req_ready(input logic req, input logic hold, input logic flush);
        return req & ~hold & ~flush;
    endfunction

endpackage

// File: rtl/req_hold_buf.sv
// rtl/req_hold_buf.sv - per-requester read buffer plus hold flag kept until its stage advances
module req_hold_buf
    import bus_arbiter_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              capture,
    input  logic              load,
    input  logic              stall_bit,
    input  logic [DATA_W-1:0] data,
    output logic              hold,
    output logic [DATA_W-1:0] rdata
);

    always_ff @(posedge clk) begin
        if (rst) begin
            hold  <= 1'b0;
            rdata <= '0;
        end else begin
            if (load) begin
                rdata <= data;
            end
            if (flush) begin
                hold <= 1'b0;
            end else if (capture) begin
                hold <= 1'b1;
            end else if (hold && stall_bit == NO_STOP) begin
                hold <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - shares one Wishbone master between fetch and data access, MEM first
module bus_arbiter
    import bus_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [5:0]          stall,
    input  logic                flush,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stallreq,
    input  logic                mem_req,
    input  logic                mem_we,
    input  logic [DATA_W/8-1:0] mem_sel,
    input  logic [ADDR_W-1:0]   mem_addr,
    input  logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W-1:0]   mem_rdata,
    output logic                mem_stallreq,
    output logic [ADDR_W-1:0]   wb_adr_o,
    output logic [DATA_W-1:0]   wb_dat_o,
    input  logic [DATA_W-1:0]   wb_dat_i,
    output logic                wb_we_o,
    output logic [DATA_W/8-1:0] wb_sel_o,
    output logic                wb_stb_o,
    output logic                wb_cyc_o,
    input  logic                wb_ack_i
);

    localparam int SEL_W = DATA_W / 8;

    arb_state_e state, state_nxt;

    logic              if_hold, mem_hold;
    logic              if_cap, if_load, mem_cap, mem_load;
    logic [ADDR_W-1:0] adr_nxt;
    logic [DATA_W-1:0] dat_nxt;
    logic [SEL_W-1:0]  sel_nxt;
    logic              we_nxt, stb_nxt, cyc_nxt;

    logic unused_stall_bits;
    assign unused_stall_bits = ^{stall[5], stall[3:2], stall[0]};

    assign if_stallreq  = req_ready(if_req, if_hold, flush);
    assign mem_stallreq = req_ready(mem_req, mem_hold, flush);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ARB_IDLE;
            wb_adr_o <= '0;
            wb_dat_o <= '0;
            wb_sel_o <= '0;
            wb_we_o  <= 1'b0;
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
        end else begin
            state    <= state_nxt;
            wb_adr_o <= adr_nxt;
            wb_dat_o <= dat_nxt;
            wb_sel_o <= sel_nxt;
            wb_we_o  <= we_nxt;
            wb_stb_o <= stb_nxt;
            wb_cyc_o <= cyc_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        adr_nxt   = wb_adr_o;
        dat_nxt   = wb_dat_o;
        sel_nxt   = wb_sel_o;
        we_nxt    = wb_we_o;
        stb_nxt   = wb_stb_o;
        cyc_nxt   = wb_cyc_o;
        if_cap    = 1'b0;
        if_load   = 1'b0;
        mem_cap   = 1'b0;
        mem_load  = 1'b0;

        case (state)
            ARB_IDLE: begin
                // MEM holds the older instruction, so it wins a tie with IF.
                if (mem_stallreq) begin
                    state_nxt = ARB_MEM_BUS;
                    adr_nxt   = mem_addr;
                    dat_nxt   = mem_wdata;
                    we_nxt    = mem_we;
                    sel_nxt   = mem_sel;
                    stb_nxt   = 1'b1;
                    cyc_nxt   = 1'b1;
                end else if (if_stallreq) begin
                    state_nxt = ARB_IF_BUS;
                    adr_nxt   = if_addr;
                    we_nxt    = WRITE_DISABLE;
                    sel_nxt   = '1;
                    stb_nxt   = 1'b1;
                    cyc_nxt   = 1'b1;
                end
            end
            ARB_IF_BUS: begin
                if (wb_ack_i) begin
                    state_nxt = ARB_IDLE;
                    stb_nxt   = 1'b0;
                    cyc_nxt   = 1'b0;
                    we_nxt    = WRITE_DISABLE;
                    if_cap    = ~flush;
                    if_load   = ~flush;
                end else if (flush) begin
                    state_nxt = ARB_DISCARD;
                end
            end
            ARB_MEM_BUS: begin
                if (wb_ack_i) begin
                    state_nxt = ARB_IDLE;
                    stb_nxt   = 1'b0;
                    cyc_nxt   = 1'b0;
                    we_nxt    = WRITE_DISABLE;
                    mem_cap   = ~flush;
                    mem_load  = ~flush & (wb_we_o == WRITE_DISABLE);
                end else if (flush) begin
                    state_nxt = ARB_DISCARD;
                end
            end
            ARB_DISCARD: begin
                // Wishbone has no abort: the flushed cycle runs to its ack, result dropped.
                if (wb_ack_i) begin
                    state_nxt = ARB_IDLE;
                    stb_nxt   = 1'b0;
                    cyc_nxt   = 1'b0;
                    we_nxt    = WRITE_DISABLE;
                end
            end
            default: state_nxt = ARB_IDLE;
        endcase
    end

    req_hold_buf #(.DATA_W(DATA_W)) u_if_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .capture   (if_cap),
        .load      (if_load),
        .stall_bit (stall[STALL_IF_BIT]),
        .data      (wb_dat_i),
        .hold      (if_hold),
        .rdata     (if_rdata)
    );

    req_hold_buf #(.DATA_W(DATA_W)) u_mem_buf (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .capture   (mem_cap),
        .load      (mem_load),
        .stall_bit (stall[STALL_MEM_BIT]),
        .data      (wb_dat_i),
        .hold      (mem_hold),
        .rdata     (mem_rdata)
    );

endmodule
